player_shot_ctrl: RTL

- Owns the player's single projectile: launch from the ship, per-frame upward motion, and pixel-accurate collision against barrier pixels during the raster scan.
- Sits directly upstream of set_barriers.
  - Consumes its registered is_barrier output.
  - Produces the damage_x / damage_y / new_damage strobe it decrements health from.
- Also supplies the shot's own pixel and colour to the display mux.

---
 rtl/player_shot_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/player_shot_ctrl.sv
// Player projectile: launch, per-frame upward motion and pixel-accurate barrier hit detection.
// Optional build macro SHOT_FIRE_LATCH_EN latches short fire presses between frame ticks.
module player_shot_ctrl #(
    parameter int SHOT_W          = 2,
    parameter int SHOT_H          = 8,
    parameter int SHOT_SPEED      = 4,
    parameter int SHIP_Y          = 440,
    parameter int SCREEN_TOP      = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        frame_tick,
    input  logic        fire,
    input  logic [10:0] ship_x,
    input  logic [10:0] xCoord,
    input  logic [10:0] yCoord,
    input  logic        is_barrier,
    output logic [10:0] damage_x,
    output logic [10:0] damage_y,
    output logic        new_damage,
    output logic        shot_active,
    output logic        is_shot,
    output logic [7:0]  rgb
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [10:0]     LAUNCH_Y = 11'(SHIP_Y - SHOT_H);
    localparam logic [10:0]     SPEED    = 11'(SHOT_SPEED);
    localparam logic [11:0]     TOP_LIM  = 12'(SCREEN_TOP + SHOT_SPEED);
    localparam logic [11:0]     W_M1     = 12'(SHOT_W - 1);
    localparam logic [11:0]     H_M1     = 12'(SHOT_H - 1);
    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {IDLE, FLIGHT, HIT_PEND, COOLDOWN} state_t;

    state_t          state, state_nx;
    logic [10:0]     shot_x, shot_x_nx, shot_y, shot_y_nx;
    logic [10:0]     x_d, y_d;
    logic [10:0]     hit_x, hit_x_nx, hit_y, hit_y_nx;
    logic            hit_lat, hit_lat_nx;
    logic [10:0]     damage_x_nx, damage_y_nx;
    logic            new_damage_nx, is_shot_nx;
    logic [CD_W-1:0] cd_cnt, cd_cnt_nx;
    logic            in_box_cur, in_box_d, fire_go, launch;

    // 12-bit compares so shot_x + SHOT_W - 1 cannot wrap at the screen edge
    function automatic logic box_hit(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] sx, input logic [10:0] sy);
        logic [11:0] x12, y12, sx12, sy12;
        x12  = {1'b0, px};
        y12  = {1'b0, py};
        sx12 = {1'b0, sx};
        sy12 = {1'b0, sy};
        return (x12 >= sx12) && (x12 <= sx12 + W_M1) &&
               (y12 >= sy12) && (y12 <= sy12 + H_M1);
    endfunction

    assign in_box_cur  = box_hit(xCoord, yCoord, shot_x, shot_y);
    assign in_box_d    = box_hit(x_d, y_d, shot_x, shot_y);
    assign shot_active = (state == FLIGHT) || (state == HIT_PEND);
    assign rgb         = is_shot ? 8'hFF : 8'h00;

`ifdef SHOT_FIRE_LATCH_EN
    logic fire_d, fire_req;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            fire_d   <= 1'b0;
            fire_req <= 1'b0;
        end else begin
            fire_d <= fire;
            if (launch)
                fire_req <= 1'b0;
            else if (fire && !fire_d && !shot_active)
                fire_req <= 1'b1;
        end
    end

    assign fire_go = fire || fire_req;
`else
    assign fire_go = fire;
`endif

    always_comb begin
        state_nx      = state;
        shot_x_nx     = shot_x;
        shot_y_nx     = shot_y;
        hit_x_nx      = hit_x;
        hit_y_nx      = hit_y;
        hit_lat_nx    = hit_lat;
        damage_x_nx   = damage_x;
        damage_y_nx   = damage_y;
        new_damage_nx = 1'b0;
        cd_cnt_nx     = cd_cnt;
        launch        = 1'b0;
        is_shot_nx    = (state == FLIGHT) && in_box_cur;
        case (state)
            IDLE: begin
                if (frame_tick && fire_go) begin
                    shot_x_nx = ship_x;
                    shot_y_nx = LAUNCH_Y;
                    launch    = 1'b1;
                    state_nx  = FLIGHT;
                end
            end
            FLIGHT: begin
                // a hit in the tick cycle wins over motion
                if (in_box_d && is_barrier && !hit_lat) begin
                    hit_lat_nx = 1'b1;
                    hit_x_nx   = x_d;
                    hit_y_nx   = y_d;
                    state_nx   = HIT_PEND;
                end else if (frame_tick) begin
                    if ({1'b0, shot_y} < TOP_LIM) begin
                        cd_cnt_nx = CD_LOAD;
                        state_nx  = COOLDOWN;
                    end else begin
                        shot_y_nx = shot_y - SPEED;
                    end
                end
            end
            HIT_PEND: begin
                if (frame_tick) begin
                    new_damage_nx = 1'b1;
                    damage_x_nx   = hit_x;
                    damage_y_nx   = hit_y;
                    hit_lat_nx    = 1'b0;
                    cd_cnt_nx     = CD_LOAD;
                    state_nx      = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (cd_cnt == '0)
                        state_nx = IDLE;
                    else
                        cd_cnt_nx = cd_cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state      <= IDLE;
            shot_x     <= '0;
            shot_y     <= '0;
            x_d        <= '0;
            y_d        <= '0;
            hit_x      <= '0;
            hit_y      <= '0;
            hit_lat    <= 1'b0;
            damage_x   <= '0;
            damage_y   <= '0;
            new_damage <= 1'b0;
            is_shot    <= 1'b0;
            cd_cnt     <= '0;
        end else begin
            state      <= state_nx;
            shot_x     <= shot_x_nx;
            shot_y     <= shot_y_nx;
            x_d        <= xCoord;
            y_d        <= yCoord;
            hit_x      <= hit_x_nx;
            hit_y      <= hit_y_nx;
            hit_lat    <= hit_lat_nx;
            damage_x   <= damage_x_nx;
            damage_y   <= damage_y_nx;
            new_damage <= new_damage_nx;
            is_shot    <= is_shot_nx;
            cd_cnt     <= cd_cnt_nx;
        end
    end

endmodule
